// File: rtl/q2_sequencer_if.sv
// Front-panel / state-code bundle between q2_sequencer and its neighbours.
//
// Signals
//   op2..op5  opcode bits from the instruction register (op2=1 indirect, op5=0 operand load)
//   run_sw    front-panel run switch (level, asynchronous)
//   step_btn  front-panel single-step button (asynchronous)
//   exam_btn  front-panel examine-next button (asynchronous)
//   dep_btn   front-panel deposit button (asynchronous)
//   s0..s3    processor state code
//   ws        write strobe, high in phase B of every state while running
//   halted    processor halted at a FETCH boundary
//   incp_db   one-clock pulse: front-panel increment of P
//   dep_sw    one-clock pulse: front-panel memory deposit
//
// Modports
//   master  the side that supplies opcode bits and panel inputs
//   slave   the sequencer itself
interface q2_sequencer_if;
    logic op2;
    logic op3;
    logic op4;
    logic op5;
    logic run_sw;
    logic step_btn;
    logic exam_btn;
    logic dep_btn;
    logic s0;
    logic s1;
    logic s2;
    logic s3;
    logic ws;
    logic halted;
    logic incp_db;
    logic dep_sw;

    modport master (
        output op2, op3, op4, op5,
        output run_sw, step_btn, exam_btn, dep_btn,
        input  s0, s1, s2, s3,
        input  ws, halted, incp_db, dep_sw
    );

    modport slave (
        input  op2, op3, op4, op5,
        input  run_sw, step_btn, exam_btn, dep_btn,
        output s0, s1, s2, s3,
        output ws, halted, incp_db, dep_sw
    );
endinterface

// File: rtl/q2_sequencer.sv
// q2_sequencer: processor state-code and write-strobe generator for q2_control.
//
// Every instruction walks FETCH(0), LOAD(1), DEREF(2), EXEC(3) and the bit-serial ALU
// states 4..3+ALU_BITS, skipping states according to the live opcode bits. Each state
// lasts two clocks: phase A (ws=0) then phase B (ws=1); the state code advances on the
// edge that ends phase B. The machine can only stop at a FETCH boundary, where the
// front panel (run, single-step, examine, deposit) takes over.
//
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    q2_sequencer_if.slave: opcode bits, panel inputs, state code, ws, halted,
//          incp_db and dep_sw pulses
//
// Parameters
//   ALU_BITS     number of bit-serial ALU states per ALU instruction, 1..12
//   SYNC_STAGES  synchroniser depth on each panel input, at least 2
module q2_sequencer #(
    parameter int unsigned ALU_BITS    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic           clk,
    input logic           rst_n,
    q2_sequencer_if.slave bus
);

    localparam logic [3:0] StFetch = 4'd0;
    localparam logic [3:0] StLoad  = 4'd1;
    localparam logic [3:0] StDeref = 4'd2;
    localparam logic [3:0] StExec  = 4'd3;
    localparam logic [3:0] StAlu0  = 4'd4;

    // One bit wider than the state code so ALU_BITS=12 (last state 15) still compares cleanly.
    localparam logic [4:0] LastAlu = 5'(3 + ALU_BITS);

    typedef enum logic {
        PhA,
        PhB
    } phase_e;

    // Panel input bit positions inside the synchroniser vectors.
    localparam int unsigned InRun  = 0;
    localparam int unsigned InStep = 1;
    localparam int unsigned InExam = 2;
    localparam int unsigned InDep  = 3;

    // ------------------------------------------------------------------
    // Panel synchronisers and rising-edge detectors
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]                  raw_in;
    logic [3:0]                  synced;
    logic [3:1]                  prev_q;

    logic run_sync;
    logic step_edge;
    logic exam_edge;
    logic dep_edge;

    assign raw_in = {bus.dep_btn, bus.exam_btn, bus.step_btn, bus.run_sw};
    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
            prev_q <= synced[3:1];
        end
    end

    assign run_sync  = synced[InRun];
    assign step_edge = synced[InStep] & ~prev_q[InStep];
    assign exam_edge = synced[InExam] & ~prev_q[InExam];
    assign dep_edge  = synced[InDep]  & ~prev_q[InDep];

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    logic [3:0] state_q, state_d;
    phase_e     phase_q, phase_d;
    logic       halted_q, halted_d;
    logic       step_q, step_d;
    logic       incp_q, incp_d;
    logic       dep_q, dep_d;

    logic [3:0] next_code;
    logic       illegal;
    logic       alu_op;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StFetch;
            phase_q  <= PhA;
            halted_q <= 1'b1;
            step_q   <= 1'b0;
            incp_q   <= 1'b0;
            dep_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            halted_q <= halted_d;
            step_q   <= step_d;
            incp_q   <= incp_d;
            dep_q    <= dep_d;
        end
    end

    // Instruction flow: which state follows the current one, using the live opcode bits.
    assign illegal = {1'b0, state_q} > LastAlu;
    assign alu_op  = (~bus.op3 & ~bus.op4) | ~bus.op5;

    always_comb begin
        next_code = StFetch;
        case (state_q)
            StFetch: begin
                if (!bus.op5) begin
                    next_code = StLoad;
                end else if (bus.op2) begin
                    next_code = StDeref;
                end else begin
                    next_code = StExec;
                end
            end
            StLoad:  next_code = bus.op2 ? StDeref : StExec;
            StDeref: next_code = StExec;
            StExec:  next_code = alu_op ? StAlu0 : StFetch;
            default: begin
                // ALU states; the last one wraps back to FETCH.
                if ({1'b0, state_q} == LastAlu) begin
                    next_code = StFetch;
                end else begin
                    next_code = state_q + 4'd1;
                end
            end
        endcase
    end

    // Next-state logic: phase stepping, halt/start and front-panel pulses.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        halted_d = halted_q;
        step_d   = step_q;
        incp_d   = 1'b0;
        dep_d    = 1'b0;

        if (illegal) begin
            // Recover to a clean instruction boundary; halted is left alone.
            state_d = StFetch;
            phase_d = PhA;
        end else if (halted_q) begin
            state_d = StFetch;
            phase_d = PhA;
            // Panel pulses win over start; a coincident step edge is lost, while a
            // still-set run switch gets another chance on the next clock.
            if (dep_edge) begin
                dep_d = 1'b1;
            end else if (exam_edge) begin
                incp_d = 1'b1;
            end else if (run_sync || step_edge) begin
                halted_d = 1'b0;
                step_d   = step_edge;
            end
        end else if (phase_q == PhA) begin
            phase_d = PhB;
        end else begin
            phase_d = PhA;
            state_d = next_code;
            // Stopping is only possible on entry to FETCH, so a dropped run switch
            // always lets the current instruction finish.
            if ((next_code == StFetch) && (!run_sync || step_q)) begin
                halted_d = 1'b1;
                step_d   = 1'b0;
            end
        end
    end

    // Outputs
    always_comb begin
        bus.s0      = state_q[0];
        bus.s1      = state_q[1];
        bus.s2      = state_q[2];
        bus.s3      = state_q[3];
        bus.ws      = (phase_q == PhB) && !halted_q;
        bus.halted  = halted_q;
        bus.incp_db = incp_q;
        bus.dep_sw  = dep_q;
    end

endmodule

// File: tb/tb_q2_sequencer.sv
// Directed bench for q2_sequencer (ALU_BITS=8, SYNC_STAGES=2).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_q2_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    int seq_q[$];

    q2_sequencer_if bus();

    q2_sequencer #(
        .ALU_BITS   (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // {halted, incp_db, dep_sw, ws, s3, s2, s1, s0}
    function automatic logic [7:0] obs();
        return {bus.halted, bus.incp_db, bus.dep_sw, bus.ws, bus.s3, bus.s2, bus.s1, bus.s0};
    endfunction

    function automatic logic [7:0] exp_run(input int s, input logic w);
        logic [3:0] code;
        code = 4'(s);
        return {3'b000, w, code};
    endfunction

    localparam logic [7:0] Halted = 8'h80;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Walk the states in seq_q, two clocks each, starting at phase A of the first.
    task automatic check_seq(input string tag);
        foreach (seq_q[i]) begin
            check($sformatf("%s S%0d A", tag, seq_q[i]), int'(obs()),
                  int'(exp_run(seq_q[i], 1'b0)));
            @(negedge clk);
            check($sformatf("%s S%0d B", tag, seq_q[i]), int'(obs()),
                  int'(exp_run(seq_q[i], 1'b1)));
            @(negedge clk);
        end
    endtask

    // Wait (bounded) for halted to reach 'want'; exp_lat>=0 also checks the clock count.
    task automatic wait_halted(input string tag, input logic want, input int exp_lat);
        int n;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus.halted == want) break;
        end
        if (exp_lat >= 0) begin
            check(tag, n, exp_lat);
        end else begin
            check(tag, int'(bus.halted), int'(want));
        end
    endtask

    // Press a button combination while halted; the pulse appears at the third falling edge.
    task automatic panel(input string tag, input logic d, input logic e, input logic s,
                         input logic [7:0] pulse);
        bus.dep_btn  = d;
        bus.exam_btn = e;
        bus.step_btn = s;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            check($sformatf("%s clk%0d", tag, n), int'(obs()),
                  int'((n == 3) ? pulse : Halted));
        end
        bus.dep_btn  = 1'b0;
        bus.exam_btn = 1'b0;
        bus.step_btn = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.op2      = 1'b0;
        bus.op3      = 1'b0;
        bus.op4      = 1'b0;
        bus.op5      = 1'b0;
        bus.run_sw   = 1'b0;
        bus.step_btn = 1'b0;
        bus.exam_btn = 1'b0;
        bus.dep_btn  = 1'b0;

        // Reset and idle
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("in reset", int'(obs()), int'(Halted));
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check($sformatf("idle %0d", i), int'(obs()), int'(Halted));
        end

        // Run: op5=0 op2=0 op3=1 op4=0 -> 0,1,3,4..11 (22 clocks)
        bus.op3    = 1'b1;
        bus.run_sw = 1'b1;
        wait_halted("start latency", 1'b0, 3);
        seq_q = {0, 1, 3, 4, 5, 6, 7, 8, 9, 10, 11};
        check_seq("alu");
        check_seq("alu2");

        // Non-ALU: op5=1 op4=1 op3=0
        bus.op5 = 1'b1;
        bus.op4 = 1'b1;
        bus.op3 = 1'b0;
        bus.op2 = 1'b0;
        seq_q = {0, 3};
        check_seq("direct");
        bus.op2 = 1'b1;
        seq_q = {0, 2, 3};
        check_seq("indirect");

        // Drop run at S=6: instruction completes, then halt
        bus.op5 = 1'b0;
        bus.op4 = 1'b0;
        bus.op3 = 1'b1;
        bus.op2 = 1'b0;
        seq_q = {0, 1, 3, 4, 5};
        check_seq("drop pre");
        bus.run_sw = 1'b0;
        seq_q = {6, 7, 8, 9, 10, 11};
        check_seq("drop post");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("halt after drop %0d", i), int'(obs()), int'(Halted));
            @(negedge clk);
        end

        // Reset at S=7 phase B
        bus.run_sw = 1'b1;
        wait_halted("restart latency", 1'b0, 3);
        seq_q = {0, 1, 3, 4, 5, 6};
        check_seq("pre reset");
        @(negedge clk);
        check("S7 B", int'(obs()), int'(exp_run(7, 1'b1)));
        rst_n = 1'b0;
        #1;
        check("async reset", int'(obs()), int'(Halted));
        @(negedge clk);
        check("held reset", int'(obs()), int'(Halted));
        rst_n = 1'b1;
        // run_sw still high across reset release
        wait_halted("run after reset", 1'b0, 3);
        bus.run_sw = 1'b0;
        bus.op5    = 1'b1;
        bus.op4    = 1'b1;
        bus.op3    = 1'b0;
        seq_q = {0, 3};
        check_seq("last instr");
        check("halt after last", int'(obs()), int'(Halted));

        // Single step: op5=0 op2=1 -> 24 clocks, second step edge ignored
        bus.op5      = 1'b0;
        bus.op4      = 1'b0;
        bus.op3      = 1'b1;
        bus.op2      = 1'b1;
        bus.step_btn = 1'b1;
        wait_halted("step latency", 1'b0, 3);
        seq_q = {0, 1, 2, 3};
        check_seq("step a");
        bus.step_btn = 1'b0;
        seq_q = {4, 5};
        check_seq("step b");
        bus.step_btn = 1'b1;
        seq_q = {6, 7, 8, 9, 10, 11};
        check_seq("step c");
        for (int i = 0; i < 6; i++) begin
            check($sformatf("halt after step %0d", i), int'(obs()), int'(Halted));
            @(negedge clk);
        end
        bus.step_btn = 1'b0;
        repeat (3) @(negedge clk);

        // Panel pulses while halted
        panel("deposit", 1'b1, 1'b0, 1'b0, 8'hA0);
        panel("examine", 1'b0, 1'b1, 1'b0, 8'hC0);
        panel("dep+exam", 1'b1, 1'b1, 1'b0, 8'hA0);
        panel("dep+step", 1'b1, 1'b0, 1'b1, 8'hA0);

        // Buttons ignored while running
        bus.op5    = 1'b1;
        bus.op4    = 1'b1;
        bus.op3    = 1'b0;
        bus.op2    = 1'b0;
        bus.run_sw = 1'b1;
        wait_halted("run for panel", 1'b0, 3);
        bus.dep_btn  = 1'b1;
        bus.exam_btn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("running pulses %0d", i), int'({bus.incp_db, bus.dep_sw}), 0);
        end
        bus.run_sw = 1'b0;
        wait_halted("final halt", 1'b1, -1);
        bus.dep_btn  = 1'b0;
        bus.exam_btn = 1'b0;
        repeat (4) @(negedge clk);
        check("final state", int'(obs()), int'(Halted));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
